// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a 32 x 16-bit register file between two req/ack requesters
// (A = core sequencer, B = debug/DMA). Latches the winning operation, drives one
// register-file strobe per cycle, captures read data, rejects illegal operations and
// adds a two-cycle exchange (read then write).
// Build option: define REGFILE_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise A has fixed priority over B.

module regfile_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ID_W   = 6,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic [2:0]        a_op,
    input  logic [ID_W-1:0]   a_id,
    input  logic [DATA_W-1:0] a_din,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic [2:0]        b_op,
    input  logic [ID_W-1:0]   b_id,
    input  logic [DATA_W-1:0] b_din,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic [DATA_W-1:0] rf_din,
    output logic [ID_W-1:0]   rf_id,
    output logic              rf_read,
    output logic              rf_write,
    output logic              rf_writeu,
    output logic              rf_inc,
    output logic              rf_dec,
    input  logic [DATA_W-1:0] rf_dout
);

    localparam logic [2:0] OpNop    = 3'd0;
    localparam logic [2:0] OpRead   = 3'd1;
    localparam logic [2:0] OpWrite  = 3'd2;
    localparam logic [2:0] OpWriteu = 3'd3;
    localparam logic [2:0] OpInc    = 3'd4;
    localparam logic [2:0] OpDec    = 3'd5;
    localparam logic [2:0] OpXchg   = 3'd6;
    localparam logic [2:0] OpRsvd   = 3'd7;

    typedef enum logic [1:0] {StIdle, StExec, StExec2, StAck} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                port_q, port_d;   // 1: B owns the operation in flight
    logic                err_q, err_d;

    logic                any_req;
    logic                gnt_b;
    logic [2:0]          sel_op;
    logic [ID_W-1:0]     sel_id;
    logic [DATA_W-1:0]   sel_din;
    logic                sel_illegal;

    assign any_req = a_req | b_req;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic prio_q;   // 1: B is favoured on a tie

    // B wins when it requests alone or when the pointer favours it.
    always_comb begin
        gnt_b = b_req & (~a_req | prio_q);
    end

    // Every grant hands preference to the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            prio_q <= ~gnt_b;
        end
    end
`else
    // Fixed priority: B only wins when A is silent.
    always_comb begin
        gnt_b = b_req & ~a_req;
    end
`endif

    // Select the winning port's operation and classify it.
    always_comb begin
        sel_op      = gnt_b ? b_op  : a_op;
        sel_id      = gnt_b ? b_id  : a_id;
        sel_din     = gnt_b ? b_din : a_din;
        sel_illegal = (sel_op == OpRsvd) || (32'(sel_id) >= NREG);
    end

    // Next-state logic: latch the winner in IDLE and sequence the strobes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        din_d   = din_q;
        port_d  = port_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    op_d   = sel_op;
                    id_d   = sel_id;
                    din_d  = sel_din;
                    port_d = gnt_b;
                    if (sel_illegal) begin
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else if (sel_op == OpNop) begin
                        err_d   = 1'b0;
                        state_d = StAck;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StExec;
                    end
                end
            end
            StExec:  state_d = (op_q == OpXchg) ? StExec2 : StAck;
            StExec2: state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched-operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            id_q    <= '0;
            din_q   <= '0;
            port_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            din_q   <= din_d;
            port_q  <= port_d;
            err_q   <= err_d;
        end
    end

    // Strobe decode: one strobe in EXEC by op, write-back in EXEC2, none elsewhere.
    always_comb begin
        rf_read   = 1'b0;
        rf_write  = 1'b0;
        rf_writeu = 1'b0;
        rf_inc    = 1'b0;
        rf_dec    = 1'b0;
        case (state_q)
            StExec: begin
                case (op_q)
                    OpRead, OpXchg: rf_read   = 1'b1;
                    OpWrite:        rf_write  = 1'b1;
                    OpWriteu:       rf_writeu = 1'b1;
                    OpInc:          rf_inc    = 1'b1;
                    OpDec:          rf_dec    = 1'b1;
                    default: ;
                endcase
            end
            StExec2: rf_write = 1'b1;
            default: ;
        endcase
    end

    assign rf_id  = id_q;
    assign rf_din = din_q;
    assign a_ack  = (state_q == StAck) & ~port_q;
    assign b_ack  = (state_q == StAck) & port_q;
    assign a_err  = a_ack & err_q;
    assign b_err  = b_ack & err_q;

    // Capture read data for the owning port during the read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (state_q == StExec && (op_q == OpRead || op_q == OpXchg)) begin
            if (port_q) begin
                b_rdata <= rf_dout;
            end else begin
                a_rdata <= rf_dout;
            end
        end
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the 32 x 16-bit register file between two requesters: port A (core sequencer) and port B (debug/DMA).
- Each requester issues one operation at a time using a req/ack handshake.
- The block arbitrates between them, latches the winning operation, and drives the register file strobes (read, write, writeu, inc, dec) and id for exactly one clock each.
- It captures read data, flags illegal operations, and adds a two-cycle exchange (read-then-write) that the register file cannot do natively.

Parameters:
- DATA_W, 16, data width; matches register file din/dout.
- ID_W, 6, register id width; matches register file id.
- NREG, 32, number of implemented registers; any id >= NREG is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held with a_op/a_id/a_din stable until a_ack.
- a_op  input  3  op code: 0 NOP, 1 READ, 2 WRITE, 3 WRITEU, 4 INC, 5 DEC, 6 XCHG, 7 reserved.
- a_id  input  ID_W  target register.
- a_din  input  DATA_W  write data.
- a_ack  output  1  one-cycle completion pulse.
- a_rdata  output  DATA_W  read data; valid with a_ack, held until the next a_ack.
- a_err  output  1  valid with a_ack: operation rejected.
- b_req, b_op, b_id, b_din, b_ack, b_rdata, b_err: identical to port A.
- rf_din  output  DATA_W  to register file din.
- rf_id  output  ID_W  to register file id.
- rf_read, rf_write, rf_writeu, rf_inc, rf_dec  output  1 each  register file strobes.
- rf_dout  input  DATA_W  from register file dout.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low): state IDLE; all rf strobes 0; rf_id 0; rf_din 0; acks 0; errs 0; rdata 0; priority pointer favours A.
- Reset mid-operation: the operation in flight is dropped with no ack. A strobe already sampled by the register file stands. The requester must re-issue.
- States: IDLE, EXEC, EXEC2, ACK.
- IDLE: if any req is high, pick a winner and latch its op, id, din and port number, then go to EXEC.
  - If the op is 7, or the id is >= NREG, go directly to ACK with err=1.
  - If the op is NOP, go to ACK with err=0.
- EXEC: drive rf_id and rf_din from the latched values. Exactly one strobe is high:
  - READ and XCHG: rf_read.
  - WRITE: rf_write.
  - WRITEU: rf_writeu.
  - INC: rf_inc.
  - DEC: rf_dec.
- EXEC, READ and XCHG: rf_dout is captured into the winner's rdata at the end of the cycle.
- EXEC transitions: XCHG goes to EXEC2; all other ops go to ACK.
- EXEC2: rf_write=1 with the latched din and id (writes after the old value is captured); then go to ACK.
- ACK: the winner's ack is 1 for this cycle only, and err is driven. Return to IDLE.
- Strobes are 0 in IDLE and ACK; never more than one strobe high in any cycle.
- Latency from the first cycle req is seen high in IDLE:
  - single ops: strobe at +1, ack at +2;
  - XCHG: ack at +3;
  - errors and NOP: ack at +1.
- A req still high in the cycle after ack is a new request.
- Ports are never granted in the same cycle. A losing request simply waits; its inputs must stay stable.
- The non-winning port's ack, err and rdata are unchanged.
- Default arbitration is fixed priority, A over B. B can starve under continuous A traffic.
- rf_din/rf_id keep their last latched values in IDLE (no glitch requirement).

Optional Feature:
- Macro: REGFILE_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit pointer is updated at each grant to favour the other port. On simultaneous requests the favoured port wins. A lone request wins regardless of the pointer. After reset, A is favoured.
- Undefined: fixed priority A > B; the pointer logic is absent.

Test Plan:
- A WRITE id=3 din=0x1234, then A READ id=3 -> rf_write pulse at +1, a_ack at +2; the read returns a_rdata=0x1234 with a_err=0.
- A XCHG id=5 din=0xBEEF with R5=0x00AA -> rf_read cycle, then rf_write cycle; a_ack at +3 with a_rdata=0x00AA; a later READ id=5 returns 0xBEEF.
- A and B both request in the same cycle (A INC id=1, B DEC id=2) -> A is served first, B is granted in the IDLE cycle after a_ack; never two strobes at once. With REGFILE_ARB_ROUND_ROBIN_EN and repeated simultaneous requests, grants alternate A, B, A, B.
- B READ id=40 and B op=7 id=0 -> no strobe; b_ack at +1 with b_err=1; b_rdata unchanged.
- rst_n pulled low during EXEC2 of an XCHG -> all outputs are 0 immediately; no ack; after release the state is IDLE and a re-issued XCHG completes normally.
- WRITEU id=7 din=0x0055 with R7=0x1111 -> rf_writeu pulse only; a subsequent READ returns 0x5511.
